// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and the combinational shift/logic/add datapath.
// No latency of its own; used inside the result stage of alu_seq.
// No flow control here; the caller owns the handshake.
package alu_pkg;

  localparam logic [3:0] OP_ROL   = 4'd0;
  localparam logic [3:0] OP_SLL   = 4'd1;
  localparam logic [3:0] OP_SRA   = 4'd2;
  localparam logic [3:0] OP_SRL   = 4'd3;
  localparam logic [3:0] OP_ADD   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_AND   = 4'd7;
  localparam logic [3:0] OP_MUL   = 4'd8;
  localparam logic [3:0] OP_MULHU = 4'd9;

  // Widest datapath the helper supports; narrower operands are zero-extended.
  localparam int MAXW = 64;

  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  typedef struct packed {
    logic [MAXW-1:0] res;
    logic            ofl;
  } alu_res_t;

  // a and b must be zero above bit w-1; sh must be below w; w is 4..64.
  function automatic alu_res_t alu_comb(
    input logic [3:0]      op,
    input logic [MAXW-1:0] a,
    input logic [MAXW-1:0] b,
    input logic            cin,
    input logic            sign,
    input logic [6:0]      sh,
    input logic [6:0]      w
  );
    logic [MAXW-1:0] one;
    logic [MAXW-1:0] mask;
    logic [MAXW-1:0] ext;
    logic [MAXW-1:0] sra;
    logic [MAXW:0]   sum;
    logic [5:0]      msb;
    logic            cout;
    logic            cmsb;
    alu_res_t        r;

    r    = '0;
    one  = {{(MAXW-1){1'b0}}, 1'b1};
    msb  = 6'(w - 7'd1);
    mask = w[6] ? '1 : ((one << w) - one);
    // Sign-fill above the operand's MSB so a full-width arithmetic shift does the job.
    ext  = a | (a[msb] ? ~mask : '0);
    sra  = $signed(ext) >>> sh;
    sum  = {1'b0, a} + {1'b0, b} + {{MAXW{1'b0}}, cin};
    cout = sum[w];
    cmsb = a[msb] ^ b[msb] ^ sum[{1'b0, msb}];

    case (op)
      OP_ROL:  r.res = ((a << sh) | (a >> (w - sh))) & mask;
      OP_SLL:  r.res = (a << sh) & mask;
      OP_SRA:  r.res = sra & mask;
      OP_SRL:  r.res = a >> sh;
      OP_ADD: begin
        r.res = sum[MAXW-1:0] & mask;
        r.ofl = sign ? (cout ^ cmsb) : cout;
      end
      OP_OR:   r.res = a | b;
      OP_XOR:  r.res = a ^ b;
      OP_AND:  r.res = a & b;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add unsigned multiplier, one multiplier bit per clock.
// WIDTH iteration edges after start; prod is the complete product while last is high.
// hold freezes the final iteration so the finished product waits for the result register.
module alu_mul_iter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               run,
  input  logic               hold,
  input  logic [WIDTH-1:0]   mcand_in,
  input  logic [WIDTH-1:0]   mplier_in,
  output logic               last,
  output logic [2*WIDTH-1:0] prod
);

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   count;
  logic [WIDTH:0]     upper;
  logic               unused_acc_lsb;

  // Next accumulator value; on the last iteration this is the finished product.
  always_comb begin
    upper = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
    prod  = {upper, acc[WIDTH-1:1]};
  end

  assign last           = (count == CNT_W'(WIDTH - 1));
  assign unused_acc_lsb = acc[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= mcand_in;
      mplier <= mplier_in;
      count  <= '0;
    end else if (run && !(last && hold)) begin
      acc    <= prod;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result and iterative MUL/MULHU.
// Latency 1 for single-cycle ops; multiply result written WIDTH edges after accept.
// in_ready drops while multiplying or while an unconsumed result is stalled.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic [3:0]       Op,
  input  logic             invA,
  input  logic             invB,
  input  logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             Ofl,
  output logic             Z,
  output logic             N,
  output logic             busy
);
  import alu_pkg::*;

  state_t             state;
  logic               mul_hi;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               accept;
  logic               is_mul;
  logic               hold;
  logic               mul_start;
  logic               mul_last;
  logic               mul_fin;
  logic [2*WIDTH-1:0] prod;
  alu_res_t           fres;
  logic               unused_fres;
  logic               ld;
  logic [WIDTH-1:0]   res_d;
  logic               ofl_d;

  assign in_a      = invA ? ~A : A;
  assign in_b      = invB ? ~B : B;
  assign in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (Op == OP_MUL) || (Op == OP_MULHU);
  assign hold      = out_valid && !out_ready;
  assign mul_start = accept && is_mul;
  assign mul_fin   = (state == ST_MUL) && mul_last && !hold;
  assign busy      = (state == ST_MUL);

  assign fres        = alu_comb(Op, MAXW'(in_a), MAXW'(in_b), Cin, sign,
                                7'(in_b[CNT_W-1:0]), 7'(WIDTH));
  assign unused_fres = ^fres.res;

  alu_mul_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (mul_start),
    .run       (busy),
    .hold      (hold),
    .mcand_in  (in_a),
    .mplier_in (in_b),
    .last      (mul_last),
    .prod      (prod)
  );

  // A multiply can only finish while no single-cycle op is being accepted.
  always_comb begin
    ld    = accept && !is_mul;
    res_d = fres.res[WIDTH-1:0];
    ofl_d = fres.ofl;
    if (mul_fin) begin
      ld    = 1'b1;
      res_d = mul_hi ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
      ofl_d = mul_hi ? 1'b0 : |prod[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mul_hi    <= 1'b0;
      out_valid <= 1'b0;
      Out       <= '0;
      Ofl       <= 1'b0;
      Z         <= 1'b0;
      N         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (mul_start) begin
          state  <= ST_MUL;
          mul_hi <= (Op == OP_MULHU);
        end
        ST_MUL:  if (mul_fin) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      if (ld) begin
        out_valid <= 1'b1;
        Out       <= res_d;
        Ofl       <= ofl_d;
        Z         <= (res_d == '0);
        N         <= res_d[WIDTH-1];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed cases plus random traffic against an arithmetic reference.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_ready, Cin, invA, invB, sign;
  logic        out_valid, out_ready, Ofl, Z, N, busy;
  logic [15:0] A, B, Out;
  logic [3:0]  Op;

  logic        in_valid32, in_ready32, Cin32, invA32, invB32, sign32;
  logic        out_valid32, out_ready32, Ofl32, Z32, N32, busy32;
  logic [31:0] A32, B32, Out32;
  logic [3:0]  Op32;

  alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .Op(Op), .invA(invA), .invB(invB), .sign(sign),
    .out_valid(out_valid), .out_ready(out_ready), .Out(Out), .Ofl(Ofl),
    .Z(Z), .N(N), .busy(busy)
  );

  alu_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .A(A32), .B(B32), .Cin(Cin32), .Op(Op32), .invA(invA32), .invB(invB32), .sign(sign32),
    .out_valid(out_valid32), .out_ready(out_ready32), .Out(Out32), .Ofl(Ofl32),
    .Z(Z32), .N(N32), .busy(busy32)
  );

  typedef struct {
    logic [15:0] res;
    logic        ofl;
    int          rdy;
  } exp_t;

  exp_t        q[$];
  int          vectors, miscompares;
  int          cyc, mul_done, n_cons, cons_cyc, acc_cyc, lat;
  logic        last_acc, last_ov, last_ofl, last_z, last_n;
  logic [15:0] last_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  // Reference: unsigned/signed integer arithmetic on the 16-bit operands.
  function automatic exp_t ref_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                  input logic cin, input logic ia, input logic ib, input logic sg);
    logic [15:0] x, y;
    logic [31:0] t;
    int          us, ss, n;
    exp_t        e;
    x = ia ? ~a : a;
    y = ib ? ~b : b;
    n = int'(y[3:0]);
    e.res = 16'h0; e.ofl = 1'b0; e.rdy = 0;
    case (op)
      OP_ROL: begin t = {x, x} << n; e.res = t[31:16]; end
      OP_SLL: e.res = x << n;
      OP_SRA: e.res = $signed(x) >>> n;
      OP_SRL: e.res = x >> n;
      OP_ADD: begin
        us = int'(x) + int'(y) + int'(cin);
        ss = int'($signed(x)) + int'($signed(y)) + int'(cin);
        e.res = us[15:0];
        e.ofl = sg ? (ss > 32767 || ss < -32768) : (us > 65535);
      end
      OP_OR:  e.res = x | y;
      OP_XOR: e.res = x ^ y;
      OP_AND: e.res = x & y;
      OP_MUL:   begin t = 32'(x) * 32'(y); e.res = t[15:0];  e.ofl = |t[31:16]; end
      OP_MULHU: begin t = 32'(x) * 32'(y); e.res = t[31:16]; end
      default: ;
    endcase
    return e;
  endfunction

  // One clock: check outputs at the falling edge, update the scoreboard, advance.
  task automatic step();
    exp_t m;
    logic exp_ov, exp_ir, exp_busy;
    @(negedge clk);
    last_acc = 1'b0;
    last_ov  = out_valid;
    if (rst_n) begin
      exp_ov   = (q.size() > 0) && (q[0].rdy <= cyc);
      exp_busy = (cyc < mul_done);
      exp_ir   = !exp_busy && (!exp_ov || out_ready);
      chk1("out_valid", out_valid, exp_ov);
      chk1("in_ready", in_ready, exp_ir);
      chk1("busy", busy, exp_busy);
      if (exp_ov && out_ready) begin
        chk("Out", 32'(Out), 32'(q[0].res));
        chk1("Ofl", Ofl, q[0].ofl);
        chk1("Z", Z, q[0].res == 16'h0);
        chk1("N", N, q[0].res[15]);
        last_out = Out; last_ofl = Ofl; last_z = Z; last_n = N;
        n_cons++;
        cons_cyc = cyc;
        void'(q.pop_front());
      end
      if (in_valid && exp_ir) begin
        m = ref_op(Op, A, B, Cin, invA, invB, sign);
        // Multiply: accept edge, then 16 iteration edges, visible the cycle after.
        if (Op == OP_MUL || Op == OP_MULHU) begin
          m.rdy    = cyc + 17;
          mul_done = cyc + 17;
        end else begin
          m.rdy = cyc + 1;
        end
        q.push_back(m);
        last_acc = 1'b1;
        acc_cyc  = cyc;
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      mul_done = 0;
    end
    cyc++;
    #1;
  endtask

  task automatic run1(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic ia, input logic ib, input logic sg);
    int c0, k;
    c0 = n_cons;
    out_ready = 1'b1;
    Op = op; A = a; B = b; Cin = cin; invA = ia; invB = ib; sign = sg;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    k = 0;
    while (n_cons == c0 && k < 40) begin
      step();
      k++;
    end
    chk("result_delivered", n_cons, c0 + 1);
    lat = cons_cyc - acc_cyc;
  endtask

  logic [3:0]  b2b_op[3];
  logic [15:0] b2b_a[3], b2b_b[3];
  int          idx, blocked, c0, ov_seen, lat32;

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; mul_done = 0; n_cons = 0;
    cons_cyc = 0; acc_cyc = 0; lat = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Cin = 1'b0; Op = '0; invA = 1'b0; invB = 1'b0; sign = 1'b0;
    in_valid32 = 1'b0; out_ready32 = 1'b0;
    A32 = '0; B32 = '0; Cin32 = 1'b0; Op32 = '0; invA32 = 1'b0; invB32 = 1'b0; sign32 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_Out", 32'(Out), 32'h0);
    chk1("rst_Ofl", Ofl, 1'b0);
    chk1("rst_Z", Z, 1'b0);
    chk1("rst_N", N, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_out_valid32", out_valid32, 1'b0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();

    run1(OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("add_lat", lat, 1);
    chk("add_s_Out", 32'(last_out), 32'h8000);
    chk1("add_s_Ofl", last_ofl, 1'b1);
    chk1("add_s_N", last_n, 1'b1);
    chk1("add_s_Z", last_z, 1'b0);
    run1(OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    chk1("add_u_Ofl", last_ofl, 1'b0);

    // XOR, AND, SRA back to back with the consumer stalled for two cycles.
    b2b_op = '{OP_XOR, OP_AND, OP_SRA};
    b2b_a  = '{16'h00FF, 16'hF0F0, 16'hF000};
    b2b_b  = '{16'h0F0F, 16'h0FF0, 16'h0004};
    c0 = n_cons; idx = 0; blocked = 0;
    invA = 1'b0; invB = 1'b0; Cin = 1'b0; sign = 1'b0;
    for (int i = 0; i < 12; i++) begin
      out_ready = (i >= 2);
      in_valid  = (idx < 3);
      if (idx < 3) begin
        Op = b2b_op[idx]; A = b2b_a[idx]; B = b2b_b[idx];
      end
      if (in_valid && !in_ready) blocked++;
      step();
      if (last_acc) idx++;
    end
    in_valid = 1'b0;
    chk1("b2b_blocked", blocked > 0, 1'b1);
    chk("b2b_delivered", n_cons - c0, 3);
    chk("b2b_last", 32'(last_out), 32'hFF00);

    run1(OP_SRA, 16'h8000, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sra_Out", 32'(last_out), 32'hFFFF);
    run1(OP_ROL, 16'h8001, 16'h0011, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rol_Out", 32'(last_out), 32'h0003);

    run1(OP_MUL, 16'h0100, 16'h0100, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("mul_lat", lat, 17);
    chk("mul_Out", 32'(last_out), 32'h0000);
    chk1("mul_Ofl", last_ofl, 1'b1);
    chk1("mul_Z", last_z, 1'b1);
    run1(OP_MULHU, 16'h0100, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mulhu_Out", 32'(last_out), 32'h0001);
    chk1("mulhu_Ofl", last_ofl, 1'b0);

    run1(4'd12, 16'hA5A5, 16'h8001, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rsv_Out", 32'(last_out), 32'h0000);
    chk1("rsv_Z", last_z, 1'b1);
    chk1("rsv_Ofl", last_ofl, 1'b0);
    chk1("rsv_N", last_n, 1'b0);

    // Reset lands on the fifth edge after a multiply is accepted.
    Op = OP_MUL; A = 16'h0003; B = 16'h0005; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk1("rstmul_out_valid", out_valid, 1'b0);
    chk1("rstmul_busy", busy, 1'b0);
    chk1("rstmul_in_ready", in_ready, 1'b1);
    ov_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      ov_seen += int'(last_ov);
    end
    chk("rstmul_no_result", ov_seen, 0);

    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      Op   = 4'($urandom_range(0, 15));
      A    = 16'($urandom);
      B    = 16'($urandom);
      Cin  = 1'($urandom_range(0, 1));
      invA = ($urandom_range(0, 3) == 0);
      invB = ($urandom_range(0, 3) == 0);
      sign = 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (40) step();

    // 32-bit instance: unsigned add overflow, then a multiply accepted as the add drains.
    A32 = 32'hFFFF_FFFF; B32 = 32'h1; Cin32 = 1'b0; sign32 = 1'b0; Op32 = OP_ADD;
    in_valid32 = 1'b1; out_ready32 = 1'b1;
    @(negedge clk);
    chk1("w32_in_ready", in_ready32, 1'b1);
    @(posedge clk);
    #1;
    in_valid32 = 1'b0;
    chk1("w32_add_valid", out_valid32, 1'b1);
    chk("w32_add_Out", Out32, 32'h0);
    chk1("w32_add_Ofl", Ofl32, 1'b1);
    chk1("w32_add_Z", Z32, 1'b1);
    A32 = 32'h0001_0000; B32 = 32'h0001_0000; Op32 = OP_MUL; in_valid32 = 1'b1;
    @(posedge clk);
    #1;
    in_valid32 = 1'b0;
    lat32 = 0;
    while (out_valid32 !== 1'b1 && lat32 < 100) begin
      @(posedge clk);
      #1;
      lat32++;
    end
    chk("w32_mul_lat", lat32, 32);
    chk("w32_mul_Out", Out32, 32'h0);
    chk1("w32_mul_Ofl", Ofl32, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
